med_dose_scheduler: RTL

- Schedules medication reminders for the medication reminder top level.
- Owns a MEM_DEPTH-entry dose table of {valid, minute-of-day}. A host config port and an internal scan engine share the table.
- On every minute tick it scans the table against the current time, queues matching doses, and drives one alarm at a time.
- Each alarm is resolved by acknowledge, snooze, or missed-dose timeout.

---
 rtl/med_dose_scheduler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/med_dose_scheduler.sv
// Medication dose scheduler: dose table, minute-tick scan engine and one-at-a-time alarm FSM.
// Define MED_SNOOZE_LIMIT_EN to turn the fourth snooze of one alarm into a missed dose.
`timescale 1ns/1ps
module med_dose_scheduler #(
  parameter int MEM_DEPTH      = 16,
  parameter int MEM_ADDR_WIDTH = 4,
  parameter int TIME_WIDTH     = 11,
  parameter int ACK_TIMEOUT    = 30,
  parameter int SNOOZE_MIN     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      min_tick,
  input  logic [TIME_WIDTH-1:0]     cur_time,
  input  logic                      cfg_we,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [TIME_WIDTH-1:0]     cfg_time,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      ack,
  input  logic                      snooze,
  output logic                      alarm,
  output logic [MEM_ADDR_WIDTH-1:0] alarm_slot,
  output logic                      missed,
  output logic [7:0]                missed_count,
  output logic [MEM_DEPTH-1:0]      pending
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam int SNZ_W = $clog2(SNOOZE_MIN + 1);
  localparam logic [TIME_WIDTH-1:0] MAX_TIME = TIME_WIDTH'(1439);

  typedef enum logic {S_IDLE, S_SCAN} scan_state_t;
  typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE} alarm_state_t;

  scan_state_t                          scan_state_q, scan_state_d;
  logic [MEM_ADDR_WIDTH-1:0]            scan_idx_q, scan_idx_d;
  logic [TIME_WIDTH-1:0]                scan_time_q, scan_time_d;
  logic [MEM_DEPTH-1:0]                 tbl_valid_q, tbl_valid_d;
  logic [MEM_DEPTH-1:0][TIME_WIDTH-1:0] tbl_time_q, tbl_time_d;
  logic [MEM_DEPTH-1:0]                 pending_q, pending_d;

  alarm_state_t                         alarm_state_q, alarm_state_d;
  logic                                 alarm_q, alarm_d;
  logic [MEM_ADDR_WIDTH-1:0]            alarm_slot_q, alarm_slot_d;
  logic [TMR_W-1:0]                     timer_q, timer_d;
  logic [SNZ_W-1:0]                     snz_q, snz_d;
  logic                                 missed_q, missed_d;
  logic [7:0]                           missed_count_q, missed_count_d;
`ifdef MED_SNOOZE_LIMIT_EN
  logic [1:0]                           snz_lim_q, snz_lim_d;
`endif

  logic                                 scan_hit;
  logic                                 clr_pend;
  logic                                 miss_evt;
  logic [MEM_ADDR_WIDTH-1:0]            lowest_idx;

  assign cfg_ready    = (scan_state_q == S_IDLE);
  assign alarm        = alarm_q;
  assign alarm_slot   = alarm_slot_q;
  assign missed       = missed_q;
  assign missed_count = missed_count_q;
  assign pending      = pending_q;

  // The table is only writable while the scanner is idle, so scan reads never race a write.
  always_comb begin
    scan_state_d = scan_state_q;
    scan_idx_d   = scan_idx_q;
    scan_time_d  = scan_time_q;
    tbl_valid_d  = tbl_valid_q;
    tbl_time_d   = tbl_time_q;
    scan_hit     = 1'b0;
    if (scan_state_q == S_IDLE) begin
      if (cfg_we) begin
        tbl_valid_d[cfg_addr] = cfg_valid;
        tbl_time_d[cfg_addr]  = cfg_time;
      end
      if (min_tick) begin
        scan_time_d  = cur_time;
        scan_idx_d   = '0;
        scan_state_d = S_SCAN;
      end
    end else begin
      scan_hit = tbl_valid_q[scan_idx_q] && (tbl_time_q[scan_idx_q] == scan_time_q) &&
                 (scan_time_q <= MAX_TIME);
      if (scan_idx_q == MEM_ADDR_WIDTH'(MEM_DEPTH - 1)) begin
        scan_state_d = S_IDLE;
      end else begin
        scan_idx_d = scan_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    lowest_idx = '0;
    for (int i = MEM_DEPTH - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest_idx = MEM_ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    alarm_state_d  = alarm_state_q;
    alarm_d        = alarm_q;
    alarm_slot_d   = alarm_slot_q;
    timer_d        = timer_q;
    snz_d          = snz_q;
    missed_d       = 1'b0;
    missed_count_d = missed_count_q;
    clr_pend       = 1'b0;
    miss_evt       = 1'b0;
`ifdef MED_SNOOZE_LIMIT_EN
    snz_lim_d      = snz_lim_q;
`endif
    case (alarm_state_q)
      A_IDLE: begin
        if (|pending_q) begin
          alarm_slot_d  = lowest_idx;
          timer_d       = '0;
          alarm_d       = 1'b1;
          alarm_state_d = A_RING;
`ifdef MED_SNOOZE_LIMIT_EN
          snz_lim_d     = 2'd0;
`endif
        end
      end
      A_RING: begin
        // ack outranks snooze and the timeout landing in the same cycle
        if (ack) begin
          clr_pend      = 1'b1;
          alarm_d       = 1'b0;
          alarm_state_d = A_IDLE;
        end else if (snooze) begin
`ifdef MED_SNOOZE_LIMIT_EN
          if (snz_lim_q == 2'd3) begin
            miss_evt = 1'b1;
          end else begin
            snz_lim_d     = snz_lim_q + 2'd1;
            snz_d         = SNZ_W'(SNOOZE_MIN);
            alarm_d       = 1'b0;
            alarm_state_d = A_SNOOZE;
          end
`else
          snz_d         = SNZ_W'(SNOOZE_MIN);
          alarm_d       = 1'b0;
          alarm_state_d = A_SNOOZE;
`endif
        end else if (min_tick) begin
          if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
            miss_evt = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        if (miss_evt) begin
          missed_d       = 1'b1;
          missed_count_d = (missed_count_q == 8'hFF) ? 8'hFF : missed_count_q + 8'd1;
          clr_pend       = 1'b1;
          alarm_d        = 1'b0;
          alarm_state_d  = A_IDLE;
        end
      end
      A_SNOOZE: begin
        if (min_tick) begin
          snz_d = snz_q - 1'b1;
          if (snz_q <= SNZ_W'(1)) begin
            timer_d       = '0;
            alarm_d       = 1'b1;
            alarm_state_d = A_RING;
          end
        end
      end
      default: begin
        alarm_d       = 1'b0;
        alarm_state_d = A_IDLE;
      end
    endcase
  end

  // A scan hit on the slot being cleared wins: it is a fresh dose for that slot.
  always_comb begin
    pending_d = pending_q;
    if (clr_pend) pending_d[alarm_slot_q] = 1'b0;
    if (scan_hit) pending_d[scan_idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_state_q   <= S_IDLE;
      scan_idx_q     <= '0;
      scan_time_q    <= '0;
      tbl_valid_q    <= '0;
      tbl_time_q     <= '0;
      pending_q      <= '0;
      alarm_state_q  <= A_IDLE;
      alarm_q        <= 1'b0;
      alarm_slot_q   <= '0;
      timer_q        <= '0;
      snz_q          <= '0;
      missed_q       <= 1'b0;
      missed_count_q <= '0;
`ifdef MED_SNOOZE_LIMIT_EN
      snz_lim_q      <= 2'd0;
`endif
    end else begin
      scan_state_q   <= scan_state_d;
      scan_idx_q     <= scan_idx_d;
      scan_time_q    <= scan_time_d;
      tbl_valid_q    <= tbl_valid_d;
      tbl_time_q     <= tbl_time_d;
      pending_q      <= pending_d;
      alarm_state_q  <= alarm_state_d;
      alarm_q        <= alarm_d;
      alarm_slot_q   <= alarm_slot_d;
      timer_q        <= timer_d;
      snz_q          <= snz_d;
      missed_q       <= missed_d;
      missed_count_q <= missed_count_d;
`ifdef MED_SNOOZE_LIMIT_EN
      snz_lim_q      <= snz_lim_d;
`endif
    end
  end

endmodule
